// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - frame-granular round-robin arbiter in front of the Ethernet TX FIFO
//
// Shares the TX FIFO write port between NUM_SRC AXI-Stream frame sources.
// The grant is held for a whole frame, the output beat is registered, and a
// frame longer than MAX_FRAME_WORDS is cut short: its last forwarded word
// carries tlast and the remainder is accepted and discarded.
//
// Ports:
//   aclk, areset        TX FIFO write clock; synchronous active-high reset
//   s_axis_tdata        NUM_SRC*32 source data, source i at [32*i+31:32*i]
//   s_axis_tvalid/tlast per-source valid / end of frame
//   s_axis_tready       per-source ready (only the granted source can be ready)
//   m_axis_tdata/tvalid/tlast  registered beat towards the TX FIFO
//   m_axis_tready       TX FIFO ready
//   grant               one-hot current owner, 0 while idle
//   frame_trunc         one-cycle pulse after a frame has been truncated

module eth_tx_arbiter #(
    parameter int NUM_SRC         = 2,
    parameter int MAX_FRAME_WORDS = 256
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NUM_SRC*32-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 frame_trunc
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_FRAME_WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] grant_r;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   word_cnt;
    logic [31:0]        m_data_r;
    logic               m_valid_r;
    logic               m_last_r;
    logic               trunc_r;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [31:0]        sel_tdata;
    logic               sel_tvalid;
    logic               sel_tlast;
    logic               rdy;
    logic               accept;
    logic               fwd;
    logic               at_limit;

    // Round-robin search: offset i from rr_ptr is tried in order, so the
    // source just after the previous winner has the highest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!win_found && (j == (int'(rr_ptr) + i) % NUM_SRC) && s_axis_tvalid[j]) begin
                    win_found = 1'b1;
                    win_idx   = PTR_W'(j);
                end
            end
        end
    end

    // Granted source mux, driven by the one-hot grant register.
    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_r[i]) begin
                sel_tdata  = s_axis_tdata[i*32 +: 32];
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
            end
        end
    end

    // The word being accepted now is the last one allowed in this frame.
    assign at_limit = (word_cnt == CNT_W'(MAX_FRAME_WORDS - 1));

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                // Single output register: a new beat fits when it is empty
                // or being drained this cycle.
                rdy = !m_valid_r || m_axis_tready;
                if (rdy && sel_tvalid) begin
                    if (sel_tlast) begin
                        state_nxt = IDLE;
                    end else if (at_limit) begin
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                rdy = 1'b1;
                if (sel_tvalid && sel_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept        = rdy && sel_tvalid;
    assign fwd           = accept && (state == BURST);
    assign s_axis_tready = grant_r & {NUM_SRC{rdy}};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            grant_r   <= '0;
            rr_ptr    <= '0;
            word_cnt  <= '0;
            m_data_r  <= '0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            trunc_r   <= 1'b0;
        end else begin
            trunc_r <= 1'b0;

            if (state == IDLE && win_found) begin
                grant_r <= NUM_SRC'(1) << win_idx;
                rr_ptr  <= PTR_W'((int'(win_idx) + 1) % NUM_SRC);
            end

            if (fwd) begin
                m_data_r  <= sel_tdata;
                m_last_r  <= sel_tlast || at_limit;
                m_valid_r <= 1'b1;
                word_cnt  <= word_cnt + 1'b1;
                trunc_r   <= at_limit && !sel_tlast;
            end else if (m_axis_tready) begin
                m_valid_r <= 1'b0;
            end

            // End of frame, whether forwarded or being dropped.
            if (accept && sel_tlast) begin
                grant_r  <= '0;
                word_cnt <= '0;
            end
        end
    end

    assign m_axis_tdata  = m_data_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tlast  = m_last_r;
    assign grant         = grant_r;
    assign frame_trunc   = trunc_r;

endmodule
